otter_intr_ctrl: RTL and testbench

OTTER_INTR_CTRL -- requirements
Module: otter_intr_ctrl

---
 rtl/otter_intr_ctrl.sv | 129 ++++++++++++
 tb/tb_otter_intr_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intr_ctrl.sv
// Interrupt controller for the OTTER core: synchronises raw sources, latches edge or level
// pending bits, and hands the lowest-index enabled source to the control unit.
module otter_intr_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned CW      = 3
) (
    input  logic               INTC_CLK,
    input  logic               INTC_RST_N,
    input  logic [NUM_SRC-1:0] INTC_SRC,
    input  logic               INTC_WR,
    input  logic [1:0]         INTC_ADDR,
    input  logic [31:0]        INTC_WDATA,
    output logic [31:0]        INTC_RDATA,
    output logic               INTC_INT,
    input  logic               INTC_TAKEN,
    input  logic               INTC_MRET,
    output logic [CW-1:0]      INTC_CAUSE
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [CW-1:0]      cause_q, cause_d;
    logic               int_q;

    logic [NUM_SRC-1:0] act, rise, clr;
    logic [CW-1:0]      top_idx;
    logic               unused_wdata;

    assign unused_wdata = ^INTC_WDATA;
    assign act          = pending_q & enable_q;
    assign rise         = sync2_q & ~prev_q;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        top_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (act[i]) top_idx = CW'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (INTC_WR && INTC_ADDR == 2'd1) clr = INTC_WDATA[NUM_SRC-1:0];
        if (state_q == StReq && INTC_TAKEN) clr[cause_q] = 1'b1;
        // A fresh edge beats any clear arriving in the same cycle.
        pending_d = (edge_mode_q & (rise | (pending_q & ~clr))) | (~edge_mode_q & sync2_q);
    end

    always_comb begin
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        if (INTC_WR && INTC_ADDR == 2'd0) enable_d    = INTC_WDATA[NUM_SRC-1:0];
        if (INTC_WR && INTC_ADDR == 2'd3) edge_mode_d = INTC_WDATA[NUM_SRC-1:0];
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            StIdle: begin
                if (act != '0) begin
                    state_d = StReq;
                    cause_d = top_idx;
                end
            end
            StReq: begin
                if (INTC_TAKEN) begin
                    state_d = StService;
                end else if (act == '0) begin
                    state_d = StIdle;
                end else begin
                    cause_d = top_idx;
                end
            end
            StService: begin
                if (INTC_MRET) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge INTC_CLK or negedge INTC_RST_N) begin
        if (!INTC_RST_N) begin
            state_q     <= StIdle;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            cause_q     <= '0;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= INTC_SRC;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            cause_q     <= cause_d;
            int_q       <= (state_d == StReq);
        end
    end

    assign INTC_INT   = int_q;
    assign INTC_CAUSE = cause_q;

    always_comb begin
        INTC_RDATA = '0;
        unique case (INTC_ADDR)
            2'd0: INTC_RDATA = 32'(enable_q);
            2'd1: INTC_RDATA = 32'(pending_q);
            2'd2: begin
                INTC_RDATA[31]     = (state_q == StService);
                INTC_RDATA[30]     = (state_q == StReq);
                INTC_RDATA[CW-1:0] = cause_q;
            end
            2'd3: INTC_RDATA = 32'(edge_mode_q);
            default: INTC_RDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: a cycle model built from the source-history rules is
// compared every cycle, and literal expectations pin key scenarios.
module tb_otter_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  src = '0;
    logic        wr = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        intr;
    logic        taken = 1'b0;
    logic        mret = 1'b0;
    logic [2:0]  cause;

    int n_checks = 0;
    int n_fail   = 0;

    otter_intr_ctrl dut (
        .INTC_CLK   (clk),
        .INTC_RST_N (rst_n),
        .INTC_SRC   (src),
        .INTC_WR    (wr),
        .INTC_ADDR  (addr),
        .INTC_WDATA (wdata),
        .INTC_RDATA (rdata),
        .INTC_INT   (intr),
        .INTC_TAKEN (taken),
        .INTC_MRET  (mret),
        .INTC_CAUSE (cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: source samples from the last three edges; sync level is two edges old.
    logic [7:0] h0 = '0, h1 = '0, h2 = '0;
    logic [7:0] m_en = '0, m_edge = '0, m_pend = '0;
    int         m_state = 0;  // 0 idle, 1 requesting, 2 in service
    int         m_cause = 0;
    bit         m_int = 1'b0;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 = '0; h1 = '0; h2 = '0;
            m_en = '0; m_edge = '0; m_pend = '0;
            m_state = 0; m_cause = 0; m_int = 1'b0;
        end else begin
            logic [7:0] act, np;
            bit         clr;
            act = m_pend & m_en;
            for (int i = 0; i < 8; i++) begin
                if (m_edge[i]) begin
                    clr = (wr && addr == 2'd1 && wdata[i]) ||
                          (m_state == 1 && taken && i == m_cause);
                    np[i] = (h1[i] && !h2[i]) || (m_pend[i] && !clr);
                end else begin
                    np[i] = h1[i];
                end
            end
            if (m_state == 0) begin
                if (act != 0) begin m_state = 1; m_cause = lowest(act); end
            end else if (m_state == 1) begin
                if (taken) m_state = 2;
                else if (act == 0) m_state = 0;
                else m_cause = lowest(act);
            end else if (mret) begin
                m_state = 0;
            end
            m_pend = np;
            if (wr && addr == 2'd0) m_en = wdata[7:0];
            if (wr && addr == 2'd3) m_edge = wdata[7:0];
            h2 = h1; h1 = h0; h0 = src;
            m_int = (m_state == 1);
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_en};
            2'd1:    return {24'd0, m_pend};
            2'd2:    return {m_state == 2, m_state == 1, 27'd0, 3'(m_cause)};
            default: return {24'd0, m_edge};
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        chk("model_int", {31'd0, intr}, {31'd0, m_int});
        chk("model_cause", {29'd0, cause}, 32'(m_cause));
        chk("model_rdata", rdata, exp_rdata(addr));
    end

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic pulse_taken();
        taken = 1'b1; @(negedge clk); taken = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1; @(negedge clk); mret = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_int", {31'd0, intr}, 32'd0);
        chk("rst_cause", {29'd0, cause}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            chk("rst_rdata", r, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single edge pulse on source 0.
        wreg(2'd0, 32'h01);
        wreg(2'd3, 32'h01);
        src = 8'h01;
        @(negedge clk);
        src = 8'h00;
        repeat (2) @(negedge clk);
        rd(2'd1, r);
        chk("s1_pend_set", r, 32'h01);
        chk("s1_int_not_yet", {31'd0, intr}, 32'd0);
        @(negedge clk);
        chk("s1_int", {31'd0, intr}, 32'd1);
        chk("s1_cause", {29'd0, cause}, 32'd0);
        pulse_taken();
        chk("s1_int_after_taken", {31'd0, intr}, 32'd0);
        rd(2'd1, r);
        chk("s1_pend_cleared", r, 32'h00);
        rd(2'd2, r);
        chk("s1_status_svc", r, 32'h8000_0000);
        pulse_mret();
        rd(2'd2, r);
        chk("s1_status_idle", r, 32'h0);

        // Two edges together: lowest index first, then the other.
        wreg(2'd0, 32'hFF);
        wreg(2'd3, 32'hFF);
        src = 8'h24;
        repeat (4) @(negedge clk);
        chk("s2_int", {31'd0, intr}, 32'd1);
        chk("s2_cause2", {29'd0, cause}, 32'd2);
        pulse_taken();
        rd(2'd2, r);
        chk("s2_status_svc", r, 32'h8000_0002);
        pulse_mret();
        @(negedge clk);
        chk("s2_int_again", {31'd0, intr}, 32'd1);
        chk("s2_cause5", {29'd0, cause}, 32'd5);
        pulse_taken();
        pulse_mret();
        src = 8'h00;
        repeat (3) @(negedge clk);

        // Level source that drops before being taken; mret while requesting is ignored.
        wreg(2'd3, 32'h00);
        wreg(2'd0, 32'h08);
        src = 8'h08;
        repeat (4) @(negedge clk);
        chk("s3_int", {31'd0, intr}, 32'd1);
        chk("s3_cause", {29'd0, cause}, 32'd3);
        pulse_mret();
        chk("s3_mret_ignored", {31'd0, intr}, 32'd1);
        src = 8'h00;
        repeat (3) @(negedge clk);
        rd(2'd1, r);
        chk("s3_pend_dropped", r, 32'h00);
        chk("s3_int_still", {31'd0, intr}, 32'd1);
        @(negedge clk);
        chk("s3_int_low", {31'd0, intr}, 32'd0);
        rd(2'd2, r);
        chk("s3_status_idle", r, 32'h3);

        // Disable while requesting; W1C racing a new edge.
        wreg(2'd3, 32'hFF);
        wreg(2'd0, 32'hFF);
        src = 8'h10;
        repeat (4) @(negedge clk);
        chk("s4_int", {31'd0, intr}, 32'd1);
        chk("s4_cause", {29'd0, cause}, 32'd4);
        wreg(2'd0, 32'h00);
        chk("s4_int_before_drop", {31'd0, intr}, 32'd1);
        @(negedge clk);
        chk("s4_int_disabled", {31'd0, intr}, 32'd0);
        src = 8'h50;
        repeat (2) @(negedge clk);
        wreg(2'd1, 32'hFF);
        rd(2'd1, r);
        chk("s4_set_beats_w1c", r, 32'h40);
        wreg(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, r);
        chk("s4_status_ro", r, 32'h4);
        src = 8'h00;
        wreg(2'd1, 32'hFF);
        repeat (3) @(negedge clk);

        // Reset while in service, then a source already high at release.
        wreg(2'd3, 32'h00);
        wreg(2'd0, 32'h02);
        src = 8'h02;
        repeat (4) @(negedge clk);
        chk("s5_int", {31'd0, intr}, 32'd1);
        pulse_taken();
        rd(2'd2, r);
        chk("s5_status_svc", r, 32'h8000_0001);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_rst_int", {31'd0, intr}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            chk("s5_rst_rdata", r, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wreg(2'd0, 32'h02);
        for (int i = 0; i < 12 && !intr; i++) @(negedge clk);
        chk("s5_int_after_rst", {31'd0, intr}, 32'd1);
        chk("s5_cause_after_rst", {29'd0, cause}, 32'd1);
        pulse_taken();
        pulse_mret();
        src = 8'h00;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
